id_ex_stage: RTL



---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: write-back sources, ALU opcodes and forwarding selects.
package pipeline_pkg;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: MEM result beats WB result beats register value;
// index x0 is never forwarded.
module fwd_mux
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [XLEN-1:0]   reg_val_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic [XLEN-1:0]   mem_val_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [XLEN-1:0]   wb_val_i,
    output fwd_sel_t          sel_o,
    output logic [XLEN-1:0]   val_o
);

    always_comb begin
        sel_o = FWD_REG;
        val_o = reg_val_i;
        if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
            sel_o = FWD_MEM;
            val_o = mem_val_i;
        end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
            sel_o = FWD_WB;
            val_o = wb_val_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and load-use bubble insertion.
// Optional stall/bubble performance counters under `ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_control,
    input  logic              id_alu_src_a,
    input  logic              id_alu_src_b,
    input  logic              id_reg_write,
    input  logic              id_mem_write,
    input  logic [1:0]        id_result_src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic              hazard_stall_o,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic [1:0]        ex_result_src,
    output logic [XLEN-1:0]   ex_write_data,
    output logic [XLEN-1:0]   ex_pc
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]        alu_ctl_q, alu_ctl_d;
    logic              src_a_q, src_a_d, src_b_q, src_b_d;
    logic              reg_write_q, reg_write_d, mem_write_q, mem_write_d;
    logic [1:0]        result_src_q, result_src_d;
    logic              bubble;

    assign hazard_stall_o = id_valid & valid_q & (result_src_q == RESULT_SRC_LOAD)
                          & (rd_q != '0) & ((rd_q == id_rs1) | (rd_q == id_rs2));

    // A hazard only bubbles the stage when neither flush nor stall overrides it.
    assign bubble = flush_i | (~stall_i & hazard_stall_o);

    always_comb begin
        valid_d      = valid_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        alu_ctl_d    = alu_ctl_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_src_d = result_src_q;
        if (bubble) begin
            valid_d      = 1'b0;
            rd1_d        = '0;
            rd2_d        = '0;
            imm_d        = '0;
            pc_d         = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            alu_ctl_d    = '0;
            src_a_d      = 1'b0;
            src_b_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = '0;
        end else if (!stall_i) begin
            valid_d      = id_valid;
            rd1_d        = id_rd1;
            rd2_d        = id_rd2;
            imm_d        = id_imm;
            pc_d         = id_pc;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
            rd_d         = id_rd;
            alu_ctl_d    = id_alu_control;
            src_a_d      = id_alu_src_a;
            src_b_d      = id_alu_src_b;
            reg_write_d  = id_reg_write;
            mem_write_d  = id_mem_write;
            result_src_d = id_result_src;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alu_ctl_q    <= '0;
            src_a_q      <= 1'b0;
            src_b_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
        end else begin
            valid_q      <= valid_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            alu_ctl_q    <= alu_ctl_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
        end
    end

    fwd_sel_t        fwd1_sel, fwd2_sel;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .ex_rs_i         (rs1_q),
        .reg_val_i       (rd1_q),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_val_i       (mem_alu_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_val_i        (wb_result),
        .sel_o           (fwd1_sel),
        .val_o           (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .ex_rs_i         (rs2_q),
        .reg_val_i       (rd2_q),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_val_i       (mem_alu_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_val_i        (wb_result),
        .sel_o           (fwd2_sel),
        .val_o           (fwd_rs2)
    );

    // Select codes are kept for debug probing only; the datapath uses the muxed values.
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^{2'(fwd1_sel), 2'(fwd2_sel)};

    assign alu_a         = src_a_q ? pc_q  : fwd_rs1;
    assign alu_b         = src_b_q ? imm_q : fwd_rs2;
    assign ex_write_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign alu_control   = alu_ctl_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_result_src = result_src_q;
    assign ex_pc         = pc_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
